qam_bit_packer: RTL and testbench

//   Packs an MSB-first byte stream into MODULATION_ORDER-QAM symbol words of
//   log2(MODULATION_ORDER) bits, ready for the Gray-coded I/Q mapper stage.

---
 rtl/qam_bit_packer.sv | 84 ++++++++
 tb/tb_qam_bit_packer.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qam_bit_packer.sv
// Packs an MSB-first byte stream into BitWidth-bit QAM symbol words for the I/Q mapper.
// Symbol widths that do not divide 8 are handled by a bit buffer; a frame's final symbol is zero-padded.
module qam_bit_packer #(
  parameter int unsigned MODULATION_ORDER = 16,
  localparam int unsigned BitWidth = $clog2(MODULATION_ORDER)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          i_byte,
  input  logic                i_dv,
  input  logic                i_last,
  output logic                o_rdy,
  output logic [BitWidth-1:0] s,
  output logic                o_dv,
  output logic                o_last,
  input  logic                i_rdy
);

  localparam int unsigned BufW = 8 + BitWidth - 1;
  localparam int unsigned CntW = $clog2(BufW + 1);

  // Valid bits are left-aligned with the oldest at the top; bits below cnt are kept zero,
  // so the final short symbol of a frame is padded for free.
  logic [BufW-1:0] bit_buf_q;
  logic [CntW-1:0] cnt_q;
  logic            last_pend_q;

  logic            free_c;
  logic            pop_c;
  logic            push_c;
  logic [BufW-1:0] buf_pop_c;
  logic [CntW-1:0] cnt_pop_c;
  logic [BufW-1:0] buf_nxt_c;
  logic [CntW-1:0] cnt_nxt_c;

  // Handshake decode and next buffer contents: pop first, then append the new byte behind what remains.
  always_comb begin
    free_c    = !o_dv | i_rdy;
    pop_c     = free_c & ((cnt_q >= CntW'(BitWidth)) | (last_pend_q & (cnt_q != '0)));
    o_rdy     = rst & !last_pend_q &
                ((cnt_q < CntW'(BitWidth)) | (pop_c & (32'(cnt_q) < 2 * BitWidth)));
    push_c    = i_dv & o_rdy;
    buf_pop_c = bit_buf_q;
    cnt_pop_c = cnt_q;
    if (pop_c) begin
      buf_pop_c = bit_buf_q << BitWidth;
      cnt_pop_c = (cnt_q >= CntW'(BitWidth)) ? cnt_q - CntW'(BitWidth) : '0;
    end
    buf_nxt_c = buf_pop_c;
    cnt_nxt_c = cnt_pop_c;
    if (push_c) begin
      buf_nxt_c = buf_pop_c | ({i_byte, {(BufW - 8){1'b0}}} >> cnt_pop_c);
      cnt_nxt_c = cnt_pop_c + CntW'(8);
    end
  end

  // Buffer, frame-end tracking and the registered symbol output stage.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bit_buf_q   <= '0;
      cnt_q       <= '0;
      last_pend_q <= 1'b0;
      s           <= '0;
      o_dv        <= 1'b0;
      o_last      <= 1'b0;
    end else begin
      bit_buf_q <= buf_nxt_c;
      cnt_q     <= cnt_nxt_c;
      if (push_c & i_last) begin
        last_pend_q <= 1'b1;
      end else if (pop_c & (cnt_pop_c == '0)) begin
        last_pend_q <= 1'b0;
      end
      if (pop_c) begin
        s      <= bit_buf_q[BufW-1 -: BitWidth];
        o_dv   <= 1'b1;
        o_last <= last_pend_q & (cnt_pop_c == '0);
      end else if (free_c) begin
        o_dv <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_qam_bit_packer.sv
// Directed and randomised-backpressure checks of qam_bit_packer at 16/64/4/256-QAM.
// One shared input stream is steered by sel to one of four packer instances.
module tb_qam_bit_packer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] i_byte;
  logic       i_dv;
  logic       i_last;
  logic       i_rdy;
  logic [1:0] sel;

  logic [3:0] dv_v, rdy_v, odv_v, olast_v;
  logic [3:0] s16;
  logic [5:0] s64;
  logic [1:0] s4;
  logic [7:0] s256;
  logic [7:0] s_sel;
  logic       dv_sel, last_sel, rdy_sel;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  bit rand_rdy = 1'b0;

  logic [7:0] q_s[$];
  logic       q_l[$];
  int         q_c[$];
  logic [7:0] sent_b[$];
  logic [7:0] exp_s[$];
  logic       exp_l[$];

  always #5 clk = ~clk;

  assign dv_v = i_dv ? (4'b0001 << sel) : 4'b0000;

  qam_bit_packer #(.MODULATION_ORDER(16)) u_m16 (
    .clk(clk), .rst(rst), .i_byte(i_byte), .i_dv(dv_v[0]), .i_last(i_last),
    .o_rdy(rdy_v[0]), .s(s16), .o_dv(odv_v[0]), .o_last(olast_v[0]), .i_rdy(i_rdy));
  qam_bit_packer #(.MODULATION_ORDER(64)) u_m64 (
    .clk(clk), .rst(rst), .i_byte(i_byte), .i_dv(dv_v[1]), .i_last(i_last),
    .o_rdy(rdy_v[1]), .s(s64), .o_dv(odv_v[1]), .o_last(olast_v[1]), .i_rdy(i_rdy));
  qam_bit_packer #(.MODULATION_ORDER(4)) u_m4 (
    .clk(clk), .rst(rst), .i_byte(i_byte), .i_dv(dv_v[2]), .i_last(i_last),
    .o_rdy(rdy_v[2]), .s(s4), .o_dv(odv_v[2]), .o_last(olast_v[2]), .i_rdy(i_rdy));
  qam_bit_packer #(.MODULATION_ORDER(256)) u_m256 (
    .clk(clk), .rst(rst), .i_byte(i_byte), .i_dv(dv_v[3]), .i_last(i_last),
    .o_rdy(rdy_v[3]), .s(s256), .o_dv(odv_v[3]), .o_last(olast_v[3]), .i_rdy(i_rdy));

  always_comb begin
    case (sel)
      2'd0:    s_sel = 8'(s16);
      2'd1:    s_sel = 8'(s64);
      2'd2:    s_sel = 8'(s4);
      default: s_sel = s256;
    endcase
    dv_sel   = odv_v[sel];
    last_sel = olast_v[sel];
    rdy_sel  = rdy_v[sel];
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Record every output transfer of the selected instance, one per cycle.
  always @(negedge clk) begin
    if (rst && dv_sel && i_rdy) begin
      q_s.push_back(s_sel);
      q_l.push_back(last_sel);
      q_c.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) i_rdy = 1'($urandom_range(0, 1));
  endtask

  task automatic clear_q();
    q_s.delete();
    q_l.delete();
    q_c.delete();
  endtask

  task automatic idle();
    i_dv   = 1'b0;
    i_last = 1'b0;
  endtask

  // Present one byte and hold it until accepted; leaves i_dv high for the caller.
  task automatic send(input logic [7:0] b, input logic l);
    bit ok = 1'b0;
    i_byte = b;
    i_last = l;
    i_dv   = 1'b1;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      if (rdy_sel) begin
        ok = 1'b1;
        acc_cyc = cyc;
      end
      tick();
    end
    sent_b.push_back(b);
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout byte %h never accepted (o_rdy stuck 0, required 1)", b);
    end
  endtask

  task automatic drain(input int n);
    for (int t = 0; t < 2000 && q_s.size() < n; t++) tick();
    repeat (4) tick();
  endtask

  // Bit-serial reference: concatenate bytes MSB first, cut into bw-bit words, zero-pad the tail.
  task automatic model(input int bw);
    int nbits;
    int nsym;
    logic [7:0] v;
    logic [7:0] tmp;
    exp_s.delete();
    exp_l.delete();
    nbits = sent_b.size() * 8;
    nsym  = (nbits + bw - 1) / bw;
    for (int k = 0; k < nsym; k++) begin
      v = 8'h00;
      for (int j = 0; j < bw; j++) begin
        int idx = k * bw + j;
        v = v << 1;
        if (idx < nbits) begin
          tmp = sent_b[idx / 8];
          v[0] = tmp[7 - (idx % 8)];
        end
      end
      exp_s.push_back(v);
      exp_l.push_back(k == nsym - 1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; i_dv = 1'b0; i_last = 1'b0; i_byte = 8'h00; i_rdy = 1'b1; sel = 2'd0;
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if (odv_v !== 4'h0) begin errors++; $display("FAIL reset_o_dv got %b exp 0000", odv_v); end
    checks++;
    if (olast_v !== 4'h0) begin errors++; $display("FAIL reset_o_last got %b exp 0000", olast_v); end
    checks++;
    if (rdy_v !== 4'h0) begin errors++; $display("FAIL reset_o_rdy_low got %b exp 0000", rdy_v); end
    checks++;
    if ({s16, s64, s4, s256} !== 20'h0) begin
      errors++; $display("FAIL reset_s got %h %h %h %h exp all 0", s16, s64, s4, s256);
    end
    tick();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (rdy_v !== 4'hF) begin errors++; $display("FAIL reset_o_rdy_release got %b exp 1111", rdy_v); end
    tick();
  endtask

  task automatic test_m16_single();
    sel = 2'd0; i_rdy = 1'b1; clear_q();
    send(8'hB4, 1'b1);
    idle();
    drain(2);
    exp_s = '{8'h0B, 8'h04};
    exp_l = '{1'b0, 1'b1};
    checks++;
    if (q_s.size() != 2) begin errors++; $display("FAIL m16_count got %0d exp 2", q_s.size()); end
    foreach (exp_s[i]) begin
      checks++;
      if (i >= q_s.size() || q_s[i] !== exp_s[i] || q_l[i] !== exp_l[i]) begin
        errors++; $display("FAIL m16_sym%0d exp s=%h last=%b", i, exp_s[i], exp_l[i]);
      end
    end
    checks++;
    if (q_c.size() < 2 || q_c[0] - acc_cyc != 2 || q_c[1] - q_c[0] != 1) begin
      errors++; $display("FAIL m16_latency got first-symbol offset/gap wrong, exp 2 then 1 cycle");
    end
  endtask

  task automatic test_m64_exact();
    sel = 2'd1; i_rdy = 1'b1; clear_q();
    send(8'hFF, 1'b0);
    send(8'h00, 1'b0);
    send(8'hA5, 1'b1);
    idle();
    drain(4);
    exp_s = '{8'h3F, 8'h30, 8'h02, 8'h25};
    exp_l = '{1'b0, 1'b0, 1'b0, 1'b1};
    checks++;
    if (q_s.size() != 4) begin errors++; $display("FAIL m64_exact_count got %0d exp 4", q_s.size()); end
    foreach (exp_s[i]) begin
      checks++;
      if (i >= q_s.size() || q_s[i] !== exp_s[i] || q_l[i] !== exp_l[i]) begin
        errors++; $display("FAIL m64_exact_sym%0d exp s=%h last=%b", i, exp_s[i], exp_l[i]);
      end
    end
    checks++;
    if (q_c.size() < 4 || q_c[3] - q_c[0] != 3) begin
      errors++; $display("FAIL m64_back_to_back symbols not on consecutive cycles");
    end
  endtask

  task automatic test_m64_pad();
    sel = 2'd1; i_rdy = 1'b1; clear_q();
    send(8'hC3, 1'b1);
    idle();
    @(negedge clk);
    checks++;
    if (rdy_sel !== 1'b0) begin errors++; $display("FAIL m64_pad_rdy_a got %b exp 0", rdy_sel); end
    tick();
    @(negedge clk);
    checks++;
    if (rdy_sel !== 1'b0) begin errors++; $display("FAIL m64_pad_rdy_b got %b exp 0", rdy_sel); end
    tick();
    @(negedge clk);
    checks++;
    if (rdy_sel !== 1'b1 || dv_sel !== 1'b1 || last_sel !== 1'b1) begin
      errors++; $display("FAIL m64_pad_end got rdy=%b dv=%b last=%b exp 1 1 1", rdy_sel, dv_sel, last_sel);
    end
    drain(2);
    exp_s = '{8'h30, 8'h30};
    exp_l = '{1'b0, 1'b1};
    checks++;
    if (q_s.size() != 2) begin errors++; $display("FAIL m64_pad_count got %0d exp 2", q_s.size()); end
    foreach (exp_s[i]) begin
      checks++;
      if (i >= q_s.size() || q_s[i] !== exp_s[i] || q_l[i] !== exp_l[i]) begin
        errors++; $display("FAIL m64_pad_sym%0d exp s=%h last=%b", i, exp_s[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_m4_m256();
    sel = 2'd2; i_rdy = 1'b1; clear_q();
    send(8'h1B, 1'b1);
    idle();
    drain(4);
    exp_s = '{8'h00, 8'h01, 8'h02, 8'h03};
    exp_l = '{1'b0, 1'b0, 1'b0, 1'b1};
    checks++;
    if (q_s.size() != 4) begin errors++; $display("FAIL m4_count got %0d exp 4", q_s.size()); end
    foreach (exp_s[i]) begin
      checks++;
      if (i >= q_s.size() || q_s[i] !== exp_s[i] || q_l[i] !== exp_l[i]) begin
        errors++; $display("FAIL m4_sym%0d exp s=%h last=%b", i, exp_s[i], exp_l[i]);
      end
    end
    sel = 2'd3; clear_q();
    send(8'h5A, 1'b0);
    send(8'h77, 1'b1);
    idle();
    drain(2);
    exp_s = '{8'h5A, 8'h77};
    exp_l = '{1'b0, 1'b1};
    checks++;
    if (q_s.size() != 2 || q_c[1] - q_c[0] != 1) begin
      errors++; $display("FAIL m256_count got %0d symbols exp 2 on consecutive cycles", q_s.size());
    end
    foreach (exp_s[i]) begin
      checks++;
      if (i >= q_s.size() || q_s[i] !== exp_s[i] || q_l[i] !== exp_l[i]) begin
        errors++; $display("FAIL m256_sym%0d exp s=%h last=%b", i, exp_s[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    sel = 2'd0; i_rdy = 1'b0; clear_q();
    send(8'hB4, 1'b0);
    i_byte = 8'h3C; i_last = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (dv_sel !== 1'b1 || s_sel !== 8'h0B || last_sel !== 1'b0 || rdy_sel !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d got dv=%b s=%h last=%b rdy=%b exp 1 0b 0 0", k, dv_sel, s_sel, last_sel, rdy_sel);
      end
      tick();
    end
    i_rdy = 1'b1;
    send(8'h3C, 1'b1);
    idle();
    drain(4);
    exp_s = '{8'h0B, 8'h04, 8'h03, 8'h0C};
    exp_l = '{1'b0, 1'b0, 1'b0, 1'b1};
    checks++;
    if (q_s.size() != 4) begin errors++; $display("FAIL bp_count got %0d exp 4", q_s.size()); end
    foreach (exp_s[i]) begin
      checks++;
      if (i >= q_s.size() || q_s[i] !== exp_s[i] || q_l[i] !== exp_l[i]) begin
        errors++; $display("FAIL bp_sym%0d exp s=%h last=%b", i, exp_s[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_random(input logic [1:0] which, input int bw, input int nbytes);
    sel = which; i_rdy = 1'b1; clear_q(); sent_b.delete();
    rand_rdy = 1'b1;
    for (int n = 0; n < nbytes; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle();
        tick();
      end
      send(8'($urandom_range(0, 255)), n == nbytes - 1);
    end
    idle();
    rand_rdy = 1'b0;
    i_rdy = 1'b1;
    model(bw);
    drain(exp_s.size());
    checks++;
    if (q_s.size() != exp_s.size()) begin
      errors++; $display("FAIL rand_bw%0d_count got %0d exp %0d", bw, q_s.size(), exp_s.size());
    end
    foreach (exp_s[i]) begin
      checks++;
      if (i >= q_s.size() || q_s[i] !== exp_s[i] || q_l[i] !== exp_l[i]) begin
        errors++; $display("FAIL rand_bw%0d_sym%0d exp s=%h last=%b", bw, i, exp_s[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_reset_midframe();
    sel = 2'd0; i_rdy = 1'b0; clear_q();
    send(8'h5E, 1'b0);
    idle();
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (rdy_sel !== 1'b0) begin errors++; $display("FAIL midrst_rdy_low got %b exp 0", rdy_sel); end
    tick();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (dv_sel !== 1'b0 || rdy_sel !== 1'b1) begin
      errors++; $display("FAIL midrst_state got dv=%b rdy=%b exp 0 1", dv_sel, rdy_sel);
    end
    tick();
    i_rdy = 1'b1; clear_q();
    send(8'hB4, 1'b1);
    idle();
    drain(2);
    exp_s = '{8'h0B, 8'h04};
    exp_l = '{1'b0, 1'b1};
    checks++;
    if (q_s.size() != 2) begin errors++; $display("FAIL midrst_count got %0d exp 2", q_s.size()); end
    foreach (exp_s[i]) begin
      checks++;
      if (i >= q_s.size() || q_s[i] !== exp_s[i] || q_l[i] !== exp_l[i]) begin
        errors++; $display("FAIL midrst_sym%0d exp s=%h last=%b", i, exp_s[i], exp_l[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_m16_single();
    test_m64_exact();
    test_m64_pad();
    test_m4_m256();
    test_backpressure();
    test_random(2'd0, 4, 200);
    test_random(2'd1, 6, 40);
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
